spi_controller: RTL and testbench

//  SPI mode-0 controller: drives sclk/ncs/copi toward the on-chip SPI peripheral (PWM register bank).

---
 rtl/spi_pkg.sv | 31 +++
 rtl/spi_sclk_gen.sv | 53 +++++
 rtl/spi_controller.sv | 190 +++++++++++++++++++
 tb/tb_spi_controller.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared constants and types for the SPI controller slice.
//   FRAME_W  : bits per SPI frame ({write, addr, data})
//   ADDR_W   : register address width
//   DATA_W   : register data width
//   MAX_ADDR : highest register address implemented by the PWM peripheral
//   spi_ctrl_state_t : controller FSM states
//   pack_frame()     : assembles the 16-bit frame from request fields
package spi_pkg;

  localparam int FRAME_W  = 16;
  localparam int ADDR_W   = 7;
  localparam int DATA_W   = 8;
  localparam int MAX_ADDR = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } spi_ctrl_state_t;

  function automatic logic [FRAME_W-1:0] pack_frame(
    input logic              write,
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] data
  );
    return {write, addr, data};
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// spi_sclk_gen: sclk divider for the SPI controller.
//   Each sclk half-period lasts CLK_DIV clk cycles. A period starts high
//   (start or an internal re-rise) and ends after its low half.
// Ports:
//   clk, rst_n  : system clock, async active-low reset
//   start       : pulse - raise sclk and begin the first period
//   run         : divider counts while high; counter parked at 0 otherwise
//   last        : current period is the final one; do not re-rise after it
//   sclk        : registered SPI clock, idle low
//   rise        : strobe - sclk goes high at this clk edge
//   fall        : strobe - sclk goes low at this clk edge
//   period_end  : strobe - low half of the current period has completed
module spi_sclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic run,
  input  logic last,
  output logic sclk,
  output logic rise,
  output logic fall,
  output logic period_end
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CNT_W-1:0] div_cnt;
  logic             half_end;

  assign half_end   = run && (div_cnt == CNT_W'(CLK_DIV - 1));
  assign fall       = half_end && sclk;
  assign period_end = half_end && !sclk;
  assign rise       = start || (period_end && !last);

  // NOTE: async reset appears in the sensitivity list; every register in
  // this slice resets asynchronously so the pins go safe without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      sclk    <= 1'b0;
    end else begin
      // Counter restarts from 0 whenever the controller (re)enters a phase.
      if (start || !run || half_end) div_cnt <= '0;
      else                           div_cnt <= div_cnt + 1'b1;

      if (rise)              sclk <= 1'b1;
      else if (fall || !run) sclk <= 1'b0;
    end
  end

endmodule

// File: rtl/spi_controller.sv
// spi_controller: SPI mode-0 controller toward the on-chip PWM register bank.
//   One accepted request {write, addr, data} becomes one 16-bit frame, MSB
//   first, inside one ncs-low window. All pins are registered.
// Optional feature macro: SPI_READBACK_EN
//   defined   : cipo is synchronised (2 FF) and bits 7..0 of the frame are
//               captured on sclk rising edges; rsp_data updates when done pulses
//   undefined : cipo unused, rsp_data tied to 8'h00
// Ports:
//   clk, rst_n          : system clock, async active-low reset
//   req_valid/req_ready : request handshake (ready only in IDLE)
//   req_write/addr/data : frame fields {bit15, bits14:8, bits7:0}
//   busy                : accept through return to IDLE
//   done                : one-cycle pulse as ncs rises at frame end
//   sclk, ncs, copi     : SPI pins (idle low, idle high, MSB first)
//   cipo                : peripheral data out
//   rsp_data            : read-back byte
module spi_controller
  import spi_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_GAP   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic              busy,
  output logic              done,
  output logic              sclk,
  output logic              ncs,
  output logic              copi,
  input  logic              cipo,
  output logic [DATA_W-1:0] rsp_data
);

  localparam int TMR_W = 16;

  spi_ctrl_state_t    state;
  logic [TMR_W-1:0]   tmr;
  logic [FRAME_W-1:0] shreg;
  logic [4:0]         bit_cnt;

  logic accept;
  logic sclk_start;
  logic sclk_run;
  logic sclk_last;
  logic sclk_rise;
  logic sclk_fall;
  logic sclk_period_end;
  logic hold_end;

  assign accept     = req_valid && req_ready;
  assign sclk_start = (state == ST_SETUP) && (tmr == TMR_W'(CS_SETUP - 1));
  assign sclk_run   = (state == ST_SHIFT);
  // bit_cnt counts completed falling edges; 16 means the whole frame is out.
  assign sclk_last  = (bit_cnt == 5'd16);
  assign hold_end   = (state == ST_HOLD) && (tmr == TMR_W'(CS_HOLD - 1));

  spi_sclk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sclk_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (sclk_start),
    .run       (sclk_run),
    .last      (sclk_last),
    .sclk      (sclk),
    .rise      (sclk_rise),
    .fall      (sclk_fall),
    .period_end(sclk_period_end)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      tmr       <= '0;
      shreg     <= '0;
      bit_cnt   <= '0;
      ncs       <= 1'b1;
      copi      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      req_ready <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          req_ready <= 1'b1;
          if (accept) begin
            shreg     <= pack_frame(req_write, req_addr, req_data);
            copi      <= req_write;
            ncs       <= 1'b0;
            busy      <= 1'b1;
            req_ready <= 1'b0;
            tmr       <= '0;
            state     <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (sclk_start) begin
            tmr     <= '0;
            bit_cnt <= '0;
            state   <= ST_SHIFT;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        ST_SHIFT: begin
          // Next bit goes out on the falling edge, so copi is stable
          // for the whole high half around each rising edge.
          if (sclk_fall) begin
            shreg   <= {shreg[FRAME_W-2:0], 1'b0};
            copi    <= shreg[FRAME_W-2];
            bit_cnt <= bit_cnt + 1'b1;
          end
          if (sclk_period_end && sclk_last) begin
            copi  <= 1'b0;
            tmr   <= '0;
            state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (hold_end) begin
            ncs   <= 1'b1;
            done  <= 1'b1;
            tmr   <= '0;
            state <= ST_GAP;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        ST_GAP: begin
          if (tmr == TMR_W'(CS_GAP - 1)) begin
            busy      <= 1'b0;
            req_ready <= 1'b1;
            tmr       <= '0;
            state     <= ST_IDLE;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        default: begin
          ncs   <= 1'b1;
          copi  <= 1'b0;
          busy  <= 1'b0;
          tmr   <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef SPI_READBACK_EN
  logic              cipo_q1;
  logic              cipo_q2;
  logic [DATA_W-1:0] rx_byte;

  // cipo changes on the peripheral's view of the falling edge; a full
  // CLK_DIV half-period passes before the next rise, so the 2-FF delay
  // is absorbed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cipo_q1  <= 1'b0;
      cipo_q2  <= 1'b0;
      rx_byte  <= '0;
      rsp_data <= '0;
    end else begin
      cipo_q1 <= cipo;
      cipo_q2 <= cipo_q1;
      // Rising edges of frame bits 7..0 are those with bit_cnt 8..15.
      if (sclk_rise && sclk_run && bit_cnt[3] && !bit_cnt[4]) begin
        rx_byte <= {rx_byte[DATA_W-2:0], cipo_q2};
      end
      if (hold_end) rsp_data <= rx_byte;
    end
  end
`else
  logic unused_cipo;
  assign unused_cipo = cipo;
  assign rsp_data    = '0;
`endif

endmodule

// File: tb/tb_spi_controller.sv
// tb_spi_controller: randomized self-checking bench for spi_controller.
//   A bus monitor decodes frames from sclk/copi, a peripheral model drives
//   cipo, and expected frames/latencies are kept in queues.
module tb_spi_controller;

  localparam int CLK_DIV  = 4;
  localparam int CS_SETUP = 2;
  localparam int CS_HOLD  = 2;
  localparam int CS_GAP   = 4;
  localparam int LATENCY  = CS_SETUP + 32 * CLK_DIV + CS_HOLD;
  localparam int T_CLK    = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_write = 1'b0;
  logic [6:0] req_addr = '0;
  logic [7:0] req_data = '0;
  logic       busy;
  logic       done;
  logic       sclk;
  logic       ncs;
  logic       copi;
  logic       cipo = 1'b0;
  logic [7:0] rsp_data;

  spi_controller #(
    .CLK_DIV (CLK_DIV),
    .CS_SETUP(CS_SETUP),
    .CS_HOLD (CS_HOLD),
    .CS_GAP  (CS_GAP)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_data (req_data),
    .busy     (busy),
    .done     (done),
    .sclk     (sclk),
    .ncs      (ncs),
    .copi     (copi),
    .cipo     (cipo),
    .rsp_data (rsp_data)
  );

  always #(T_CLK / 2) clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference state
  logic [15:0] exp_q[$];
  time         acc_q[$];
  int          n_sent = 0;
  int          n_acc = 0;
  logic [15:0] mon_frame = '0;
  int          mon_edges = 0;
  int          fall_cnt = 0;
  logic [7:0]  cur_resp = '0;
  logic [7:0]  next_resp = '0;
  time         last_rise = 0;
  bit          have_rise = 0;
  logic        prev_done = 1'b0;

  // Count every accept seen at a clock edge.
  initial forever begin
    @(posedge clk);
    if (rst_n && req_valid && req_ready) n_acc++;
  end

  // Copi sampled on sclk rising edges, only inside the ncs window.
  initial forever begin
    @(posedge sclk);
    if (!ncs && rst_n) begin
      mon_frame = {mon_frame[14:0], copi};
      mon_edges++;
    end
  end

  // Peripheral model: after falling edge k it presents frame bit k; bits
  // 8..15 carry the response byte MSB first.
  initial forever begin
    @(negedge sclk);
    if (!ncs && rst_n) begin
      fall_cnt++;
      if (fall_cnt >= 8 && fall_cnt <= 15) cipo = cur_resp[15 - fall_cnt];
      else cipo = 1'b0;
    end
  end

  initial forever begin
    @(negedge ncs);
    if (have_rise) check("ncs_gap_ok", (($time - last_rise) / T_CLK) >= CS_GAP, 1);
    mon_frame = '0;
    mon_edges = 0;
    fall_cnt  = 0;
    cur_resp  = next_resp;
    cipo      = 1'b0;
  end

  initial forever begin
    @(posedge ncs);
    if (!rst_n) begin
      // Frame abandoned by reset.
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      acc_q.delete();
      have_rise = 0;
    end else begin
      check("sclk_edges", mon_edges, 16);
      if (exp_q.size() == 0) check("frame_unexpected", 1, 0);
      else check("frame", mon_frame, exp_q.pop_front());
      last_rise = $time;
      have_rise = 1;
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n && done) begin
      if (acc_q.size() == 0) check("done_unexpected", 1, 0);
      else check("latency", ($time - T_CLK / 2 - acc_q.pop_front()) / T_CLK, LATENCY);
      check("done_width", prev_done, 0);
      check("ncs_at_done", ncs, 1);
      check("ready_in_gap", req_ready, 0);
`ifdef SPI_READBACK_EN
      check("rsp_data", rsp_data, cur_resp);
`else
      check("rsp_data", rsp_data, 0);
`endif
    end
    prev_done = done;
  end

  task automatic send(input logic w, input logic [6:0] a, input logic [7:0] d);
    bit got;
    got = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_data  = d;
    for (int i = 0; i < 400 && !got; i++) begin
      @(posedge clk);
      if (req_ready) begin
        got = 1;
        acc_q.push_back($time);
        exp_q.push_back({w, a, d});
        n_sent++;
      end
    end
    check("accept_timeout", got, 1);
    @(negedge clk);
    req_valid = 1'b0;
    req_write = 1'($urandom);
    req_addr  = 7'($urandom);
    req_data  = 8'($urandom);
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 0;
    for (int i = 0; i < 400 && !idle; i++) begin
      @(negedge clk);
      if (!busy && req_ready) idle = 1;
    end
    check("idle_timeout", idle, 1);
  endtask

  initial begin
    #(200000 * T_CLK);
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
    $fatal(1);
  end

  initial begin
    // 1: reset values
    #(3 * T_CLK + 2);
    check("rst_ncs", ncs, 1);
    check("rst_sclk", sclk, 0);
    check("rst_copi", copi, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_rsp", rsp_data, 0);
    check("rst_ready_low", req_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", req_ready, 1);

    // 2: single write, directed
    next_resp = 8'h3C;
    send(1'b1, 7'h01, 8'hA5);
    wait_idle();

    // 3: back-to-back requests
    send(1'b1, 7'h02, 8'h3C);
    send(1'b1, 7'h04, 8'hFF);
    wait_idle();

    // 4: reset after the 5th rising edge
    send(1'b0, 7'h03, 8'h96);
    begin
      bit seen;
      seen = 0;
      for (int i = 0; i < 300 && !seen; i++) begin
        @(negedge clk);
        if (mon_edges >= 5) seen = 1;
      end
      check("edge5_timeout", seen, 1);
    end
    #2 rst_n = 1'b0;
    #1;
    check("midrst_ncs", ncs, 1);
    check("midrst_sclk", sclk, 0);
    check("midrst_copi", copi, 0);
    check("midrst_busy", busy, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_midrst", req_ready, 1);
    send(1'b1, 7'h02, 8'h5C);
    wait_idle();

    // 5: read-back of 0x5A
    next_resp = 8'h5A;
    send(1'b0, 7'h00, 8'h00);
    wait_idle();

    // 6: req_valid pulsed while busy
    send(1'b1, 7'h01, 8'h77);
    repeat (10) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1;
      req_data  = 8'($urandom);
      repeat (1 + $urandom_range(0, 3)) @(negedge clk);
      req_valid = 1'b0;
      repeat (1 + $urandom_range(0, 5)) @(negedge clk);
    end
    wait_idle();
    check("no_accept_while_busy", n_acc, n_sent);

    // Randomized traffic, mixed back-to-back and idle gaps
    for (int i = 0; i < 8; i++) begin
      next_resp = 8'($urandom);
      send(1'($urandom), 7'($urandom_range(0, 4)), 8'($urandom));
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(0, 200)) @(negedge clk);
    end
    wait_idle();
    repeat (5) @(negedge clk);

    check("frames_pending", exp_q.size(), 0);
    check("accepts_pending", acc_q.size(), 0);
    check("accept_count", n_acc, n_sent);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
